// File: rtl/cam_frame_writer_pkg.sv
// cam_pkg: shared types and defaults for the camera frame writer.
package cam_pkg;
    localparam int DEF_FRAME_WORDS = 25600;
    localparam int CAM_ADDR_W = 15;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    typedef logic [15:0] rgb565_t;

    typedef struct packed {
        logic [CAM_ADDR_W-1:0] addr;
        logic [3:0]            be;
        logic [31:0]           data;
    } fifo_entry_t;
endpackage

// File: rtl/cam_frame_writer_if.sv
// cam_frame_writer_if: Avalon-MM write bundle between the frame writer and the frame RAM.
interface cam_frame_writer_if;
    import cam_pkg::*;
    logic [CAM_ADDR_W-1:0] address;
    logic [3:0]            byteenable;
    logic                  chipselect;
    logic                  write;
    logic [31:0]           writedata;
    logic                  waitrequest;

    modport master (output address, byteenable, chipselect, write, writedata, input waitrequest);
    modport slave  (input address, byteenable, chipselect, write, writedata, output waitrequest);
endinterface

// File: rtl/cam_frame_writer_fifo.sv
// cam_word_fifo: synchronous show-ahead FIFO of packed frame words.
module cam_word_fifo
    import cam_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  fifo_entry_t din,
    output logic        full,
    output logic        empty,
    output fifo_entry_t head
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_cnt;
    logic           w_push_ok;
    logic           w_pop_ok;

    assign full      = r_cnt == (AW+1)'(DEPTH);
    assign empty     = r_cnt == '0;
    assign head      = r_mem[r_rd];
    assign w_pop_ok  = pop & ~empty;
    // a pop in the same cycle frees the slot a push into a full FIFO needs
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= r_wr + AW'(w_push_ok);
            r_rd  <= r_rd + AW'(w_pop_ok);
            r_cnt <= r_cnt + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
        end
    end

    always_ff @(posedge clk)
        if (w_push_ok) r_mem[r_wr] <= din;
endmodule

// File: rtl/cam_frame_writer.sv
// cam_frame_writer: packs RGB565 pixels two per word and writes them to frame RAM over Avalon-MM.
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int FRAME_WORDS = DEF_FRAME_WORDS,
    parameter int FIFO_DEPTH  = 8,
    parameter int ADDR_W      = CAM_ADDR_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               pix_valid,
    input  rgb565_t            pix_data,
    input  logic               pix_sof,
    input  logic               pix_eof,
    input  logic               status_clear,
    cam_frame_writer_if.master bus,
    output logic               busy,
    output logic               frame_done,
    output logic               fifo_overflow,
    output logic               frame_overrun
);
    state_t            r_state;
    logic              r_phase;
    rgb565_t           r_lo;
    logic [ADDR_W-1:0] r_addr;

    logic              w_accept;
    logic              w_ph;
    logic              w_want;
    logic              w_in_range;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drained;
    logic [ADDR_W-1:0] w_addr;
    fifo_entry_t       w_din;
    fifo_entry_t       w_head;

    assign w_accept   = pix_valid & (r_state == CAPTURE | (r_state == IDLE & enable & pix_sof));
    // sof restarts packing: treat the pixel as phase 0 of word 0
    assign w_ph       = r_phase & ~pix_sof;
    assign w_addr     = pix_sof ? '0 : r_addr;
    assign w_want     = w_accept & (w_ph | pix_eof);
    assign w_in_range = int'(w_addr) < FRAME_WORDS;
    assign w_push     = w_want & w_in_range;
    assign w_pop      = ~w_empty & ~bus.waitrequest;
    assign w_drained  = r_state == DRAIN & w_empty;
    assign w_din      = '{addr: w_addr, be: w_ph ? 4'hF : 4'h3,
                          data: w_ph ? {pix_data, r_lo} : {16'h0, pix_data}};

    cam_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push),
        .pop     (w_pop),
        .din     (w_din),
        .full    (w_full),
        .empty   (w_empty),
        .head    (w_head)
    );

    // head fields are gated so the bus reads all-zero while nothing is queued
    assign bus.write      = ~w_empty;
    assign bus.chipselect = ~w_empty;
    assign bus.address    = w_empty ? '0 : w_head.addr;
    assign bus.byteenable = w_empty ? '0 : w_head.be;
    assign bus.writedata  = w_empty ? '0 : w_head.data;
    assign busy           = r_state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= IDLE;
            r_phase       <= 1'b0;
            r_lo          <= '0;
            r_addr        <= '0;
            frame_done    <= 1'b0;
            fifo_overflow <= 1'b0;
            frame_overrun <= 1'b0;
        end else begin
            frame_done <= w_drained;
            if (w_drained)
                r_state <= IDLE;
            else if (w_accept)
                r_state <= pix_eof ? DRAIN : CAPTURE;
            if (w_accept) begin
                r_phase <= ~w_ph & ~pix_eof;
                if (!w_ph) r_lo <= pix_data;
                // addr saturates at FRAME_WORDS; dropped-on-full words still advance it
                r_addr  <= (w_want & w_in_range) ? w_addr + ADDR_W'(1) : w_addr;
            end
            fifo_overflow <= (w_push & w_full & ~w_pop) | (fifo_overflow & ~status_clear);
            frame_overrun <= (w_want & ~w_in_range) | (frame_overrun & ~status_clear);
        end
    end
endmodule

// File: tb/tb_cam_frame_writer.sv
// tb_cam_frame_writer: vector table, directed corner cases and random frames against a queue model.
module tb_cam_frame_writer;
    import cam_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic    reset_n, enable, pix_valid, pix_sof, pix_eof, status_clear, waitrequest;
    rgb565_t pix_data;
    logic [1:0] busy, frame_done, fifo_overflow, frame_overrun;

    cam_frame_writer_if bus0 ();
    cam_frame_writer_if bus1 ();
    assign bus0.waitrequest = waitrequest;
    assign bus1.waitrequest = waitrequest;

    cam_frame_writer dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eof(pix_eof), .status_clear(status_clear), .bus(bus0.master),
        .busy(busy[0]), .frame_done(frame_done[0]), .fifo_overflow(fifo_overflow[0]),
        .frame_overrun(frame_overrun[0])
    );

    cam_frame_writer #(.FRAME_WORDS(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eof(pix_eof), .status_clear(status_clear), .bus(bus1.master),
        .busy(busy[1]), .frame_done(frame_done[1]), .fifo_overflow(fifo_overflow[1]),
        .frame_overrun(frame_overrun[1])
    );

    int total = 0;
    int bad = 0;
    bit chk_on = 0;

    int          st [2];
    int          ph [2];
    int          addr [2];
    rgb565_t     lo [2];
    bit          done [2];
    bit          ovf [2];
    bit          ovr [2];
    fifo_entry_t mq [2][$];
    fifo_entry_t wlog [$];

    typedef struct packed {
        bit          v, s, e;
        logic [15:0] d;
        bit          wr;
        logic [14:0] a;
        logic [3:0]  be;
        logic [31:0] dat;
        bit          busy, done;
    } vec_t;

    vec_t tv [13] = '{
        '{1'b1, 1'b1, 1'b0, 16'h1111, 1'b0, 15'd0, 4'h0, 32'h0,        1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 16'h2222, 1'b1, 15'd0, 4'hF, 32'h22221111, 1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 16'h3333, 1'b0, 15'd0, 4'h0, 32'h0,        1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b1, 16'h4444, 1'b1, 15'd1, 4'hF, 32'h44443333, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b0, 1'b1},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b0, 1'b0},
        '{1'b1, 1'b1, 1'b0, 16'hAAAA, 1'b0, 15'd0, 4'h0, 32'h0,        1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b0, 16'hBBBB, 1'b1, 15'd0, 4'hF, 32'hBBBBAAAA, 1'b1, 1'b0},
        '{1'b1, 1'b0, 1'b1, 16'hCCCC, 1'b1, 15'd1, 4'h3, 32'h0000CCCC, 1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b1, 1'b0},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b0, 1'b1},
        '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 15'd0, 4'h0, 32'h0,        1'b0, 1'b0}
    };

    task automatic chk(string n, logic [63:0] a, logic [63:0] x);
        total++;
        if (a !== x) begin
            bad++;
            $display("FAIL %s got=%h want=%h", n, a, x);
        end
    endtask

    function automatic logic [52:0] act_bus(int k);
        return k == 0 ? {bus0.write, bus0.chipselect, bus0.address, bus0.byteenable, bus0.writedata}
                      : {bus1.write, bus1.chipselect, bus1.address, bus1.byteenable, bus1.writedata};
    endfunction

    function automatic logic [52:0] exp_bus(int k);
        if (mq[k].size() == 0) return '0;
        return {2'b11, mq[k][0].addr, mq[k][0].be, mq[k][0].data};
    endfunction

    // word-level model: pixels accumulate into words, words queue up to 8 deep and leave on accepted writes
    task automatic model_step(int k);
        int s0 = st[k];
        int fw = k == 0 ? DEF_FRAME_WORDS : 4;
        bit so = 0;
        bit sf = 0;
        fifo_entry_t e;
        if (!reset_n) begin
            st[k] = 0; ph[k] = 0; addr[k] = 0; lo[k] = '0;
            mq[k].delete();
            done[k] = 0; ovf[k] = 0; ovr[k] = 0;
            return;
        end
        done[k] = s0 == 2 && mq[k].size() == 0;
        if (done[k]) st[k] = 0;
        if (mq[k].size() > 0 && !waitrequest) void'(mq[k].pop_front());
        if (pix_valid && (s0 == 1 || (s0 == 0 && enable && pix_sof))) begin
            if (pix_sof) begin ph[k] = 0; addr[k] = 0; end
            if (ph[k] == 0 && !pix_eof) begin
                lo[k] = pix_data;
                ph[k] = 1;
            end else begin
                e.addr = CAM_ADDR_W'(addr[k]);
                e.be   = ph[k] == 1 ? 4'hF : 4'h3;
                e.data = ph[k] == 1 ? {pix_data, lo[k]} : {16'h0, pix_data};
                ph[k] = 0;
                if (addr[k] >= fw) so = 1;
                else begin
                    if (mq[k].size() >= 8) sf = 1;
                    else mq[k].push_back(e);
                    addr[k]++;
                end
            end
            st[k] = pix_eof ? 2 : 1;
        end
        ovf[k] = sf || (ovf[k] && !status_clear);
        ovr[k] = so || (ovr[k] && !status_clear);
    endtask

    initial forever begin
        @(posedge clk);
        if (chk_on && bus0.write && !waitrequest)
            wlog.push_back('{addr: bus0.address, be: bus0.byteenable, data: bus0.writedata});
        for (int k = 0; k < 2; k++) model_step(k);
    end

    initial forever begin
        @(negedge clk);
        if (chk_on)
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("model_bus%0d", k), 64'(act_bus(k)), 64'(exp_bus(k)));
                chk($sformatf("model_status%0d", k),
                    64'({busy[k], frame_done[k], fifo_overflow[k], frame_overrun[k]}),
                    64'({st[k] != 0, done[k], ovf[k], ovr[k]}));
            end
    end

    task automatic drive(bit v, bit s, bit e, rgb565_t d);
        pix_valid = v; pix_sof = s; pix_eof = e; pix_data = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(bit rnd);
        int n = 0;
        drive(0, 0, 0, '0);
        while (busy != 2'b00 && n < 300) begin
            waitrequest = rnd ? 1'($urandom_range(1)) : 1'b0;
            step();
            n++;
        end
        waitrequest = 1'b0;
        chk("idle_timeout", 64'(busy), 64'(0));
    endtask

    task automatic chk_word(string n, int j, fifo_entry_t x);
        chk(n, wlog.size() > j ? 64'(wlog[j]) : '1, 64'(x));
    endtask

    initial begin
        reset_n = 0; enable = 0; status_clear = 0; waitrequest = 0;
        drive(0, 0, 0, '0);
        step();
        step();
        chk_on = 1;
        chk("reset_bus", 64'(act_bus(0)), 64'(0));
        chk("reset_status", 64'({busy, frame_done, fifo_overflow, frame_overrun}), 64'(0));
        reset_n = 1; enable = 1;

        foreach (tv[i]) begin
            drive(tv[i].v, tv[i].s, tv[i].e, tv[i].d);
            step();
            chk($sformatf("vec%0d_bus", i), 64'(act_bus(0)),
                64'({tv[i].wr, tv[i].wr, tv[i].a, tv[i].be, tv[i].dat}));
            chk($sformatf("vec%0d_status", i), 64'({busy[0], frame_done[0]}), 64'({tv[i].busy, tv[i].done}));
        end

        wlog.delete();
        waitrequest = 1;
        for (int i = 0; i < 20; i++) begin
            if (i < 18) drive(1, i == 0, i == 17, rgb565_t'(16'h0100 + i));
            else drive(0, 0, 0, '0);
            step();
            if (i >= 1) chk("stall_hold", 64'(act_bus(0)), 64'({2'b11, 15'd0, 4'hF, 32'h01010100}));
        end
        chk("stall_overflow", 64'({fifo_overflow[0], frame_overrun[0]}), 64'(2'b10));
        chk("stall_overrun4", 64'(frame_overrun[1]), 64'(1));
        wait_idle(0);
        chk("stall_count", 64'(wlog.size()), 64'(8));
        for (int j = 0; j < 8; j++)
            chk_word($sformatf("stall_word%0d", j), j,
                     '{addr: 15'(j), be: 4'hF, data: {16'(16'h0101 + 2 * j), 16'(16'h0100 + 2 * j)}});
        status_clear = 1;
        step();
        status_clear = 0;
        chk("clear_flags", 64'({fifo_overflow, frame_overrun}), 64'(0));

        wlog.delete();
        drive(1, 1, 0, 16'hA000); step();
        drive(1, 0, 0, 16'hA001); step();
        drive(1, 0, 0, 16'hA002); step();
        drive(1, 1, 0, 16'hB000); step();
        drive(1, 0, 0, 16'hB001); step();
        drive(1, 0, 1, 16'hB002); step();
        wait_idle(0);
        chk("resync_count", 64'(wlog.size()), 64'(3));
        chk_word("resync_w0", 0, '{addr: 15'd0, be: 4'hF, data: 32'hA001A000});
        chk_word("resync_w1", 1, '{addr: 15'd0, be: 4'hF, data: 32'hB001B000});
        chk_word("resync_w2", 2, '{addr: 15'd1, be: 4'h3, data: 32'h0000B002});

        waitrequest = 1;
        for (int i = 0; i < 20; i++) begin
            drive(1, i == 0, 0, rgb565_t'(16'h7000 + i));
            step();
        end
        chk("prereset_flag", 64'(fifo_overflow[0]), 64'(1));
        reset_n = 0;
        drive(0, 0, 0, '0);
        step();
        reset_n = 1; waitrequest = 0;
        chk("midreset_bus", 64'({act_bus(1), act_bus(0)}), 64'(0));
        chk("midreset_status", 64'({busy, frame_done, fifo_overflow, frame_overrun}), 64'(0));
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, rgb565_t'(16'h7100 + i));
            step();
            chk("postreset_quiet", 64'({busy, frame_done, bus0.write}), 64'(0));
        end
        wlog.delete();
        drive(1, 1, 0, 16'h5555); step();
        drive(1, 0, 1, 16'h6666); step();
        wait_idle(0);
        chk_word("restart_w0", 0, '{addr: 15'd0, be: 4'hF, data: 32'h66665555});

        for (int f = 0; f < 150; f++) begin
            int len = $urandom_range(1, 40);
            enable = $urandom_range(9) != 0;
            for (int i = 0; i < len; i++) begin
                while ($urandom_range(3) == 0) begin
                    drive(0, 0, 0, '0);
                    waitrequest = $urandom_range(2) == 0;
                    step();
                end
                drive(1, i == 0 || $urandom_range(30) == 0, i == len - 1, rgb565_t'($urandom));
                waitrequest = $urandom_range(2) == 0;
                status_clear = $urandom_range(15) == 0;
                reset_n = $urandom_range(199) != 0;
                step();
                status_clear = 0;
                reset_n = 1;
            end
            wait_idle(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
